// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the Tom & Jerry game sequencer.
//   state_t   : game phase encoding (IDLE, COUNTDOWN, PLAY, OVER)
//   WIN_*     : winner codes as reported by the collision logic
//   SCORE_W   : width of each per-player round score
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    OVER      = 2'd3
  } state_t;

  localparam logic [1:0] WIN_TOM   = 2'b10;
  localparam logic [1:0] WIN_JERRY = 2'b01;
  localparam logic [1:0] WIN_NONE  = 2'b00;

  localparam int SCORE_W = 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

endpackage

// File: rtl/game_if.sv
// game_if: bundle between the input/UART layer, the gameplay/draw modules
// and the game sequencer.
//   start, restart_local, restart_remote : single-cycle request pulses
//   gameover  : collision logic result level (2'b10 Tom, 2'b01 Jerry)
//   state     : current phase, over : latched winner, game_rst : re-init pulse
//   count     : countdown seconds, time_left : play seconds remaining
//   score_tom, score_jerry : saturating round scores
// The master modport drives the requests; the slave modport is the sequencer.
interface game_if;
  import game_pkg::*;

  logic               start;
  logic               restart_local;
  logic               restart_remote;
  logic [1:0]         gameover;
  logic [1:0]         state;
  logic [1:0]         over;
  logic               game_rst;
  logic [3:0]         count;
  logic [7:0]         time_left;
  logic [SCORE_W-1:0] score_tom;
  logic [SCORE_W-1:0] score_jerry;

  modport master (
    output start, restart_local, restart_remote, gameover,
    input  state, over, game_rst, count, time_left, score_tom, score_jerry
  );

  modport slave (
    input  start, restart_local, restart_remote, gameover,
    output state, over, game_rst, count, time_left, score_tom, score_jerry
  );

endinterface

// File: rtl/game_ctrl_sec_tick.sv
// sec_tick: one-second tick generator.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   clr  : restarts the second from zero (driven on every phase entry)
//   tick : one-cycle strobe in the last cycle of each CLK_HZ-cycle second
// With clr asserted in the cycle a phase change is decided, the counter reads
// zero in the first cycle of the new phase and tick fires in its
// (CLK_HZ-1)th cycle, so the phase consuming it changes exactly CLK_HZ cycles
// after entry.
module sec_tick #(
  parameter int CLK_HZ = 65_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: top-level game sequencer for the two-player Tom & Jerry game.
//   clk : system clock (single domain)
//   rst : asynchronous active-high reset; every output returns to zero
//   bus : game_if.slave
//         in : start, restart_local, restart_remote, gameover
//         out: state, over, game_rst, count, time_left, score_tom, score_jerry
// Phases IDLE -> COUNTDOWN -> PLAY -> OVER -> COUNTDOWN ... . All outputs are
// registers; a decision taken from the inputs/tick in one cycle is visible in
// the next.
module game_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ    = 65_000_000,
  parameter int COUNT_SEC = 3,
  parameter int ROUND_SEC = 60
) (
  input  logic    clk,
  input  logic    rst,
  game_if.slave   bus
);

  localparam logic [3:0] COUNT_LOAD = 4'(COUNT_SEC);
  localparam logic [7:0] ROUND_LOAD = 8'(ROUND_SEC);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         over_q, over_d;
  logic               grst_q, grst_d;
  logic [3:0]         count_q, count_d;
  logic [7:0]         time_q, time_d;
  logic [SCORE_W-1:0] tom_q, tom_d;
  logic [SCORE_W-1:0] jer_q, jer_d;
  logic               rl_q, rl_d;
  logic               rr_q, rr_d;

  logic tick;
  logic clr;
  logic go_tom;
  logic go_jerry;
  logic rl_seen;
  logic rr_seen;

  sec_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // 2'b11 and 2'b00 are both "no event"
  assign go_tom   = (bus.gameover == WIN_TOM);
  assign go_jerry = (bus.gameover == WIN_JERRY);

  // A restart request counts if it was seen earlier or is arriving now
  assign rl_seen  = rl_q | bus.restart_local;
  assign rr_seen  = rr_q | bus.restart_remote;

  // Decision stage: next phase and next register values
  always_comb begin
    state_d = state_q;
    over_d  = over_q;
    grst_d  = 1'b0;
    count_d = count_q;
    time_d  = time_q;
    tom_d   = tom_q;
    jer_d   = jer_q;
    rl_d    = rl_q;
    rr_d    = rr_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = COUNTDOWN;
          count_d = COUNT_LOAD;
          time_d  = '0;
          grst_d  = 1'b1;
        end
      end

      COUNTDOWN: begin
        if (tick) begin
          if (count_q <= 4'd1) begin
            state_d = PLAY;
            count_d = '0;
            time_d  = ROUND_LOAD;
          end else begin
            count_d = count_q - 4'd1;
          end
        end
      end

      PLAY: begin
        // A collision result outranks a simultaneous final tick; time_left
        // then keeps the value it had when the round was decided.
        if (go_tom) begin
          state_d = OVER;
          over_d  = WIN_TOM;
          tom_d   = sat_inc(tom_q);
        end else if (go_jerry) begin
          state_d = OVER;
          over_d  = WIN_JERRY;
          jer_d   = sat_inc(jer_q);
        end else if (tick) begin
          if (time_q <= 8'd1) begin
            // Running out the clock is a Jerry win
            state_d = OVER;
            over_d  = WIN_JERRY;
            jer_d   = sat_inc(jer_q);
            time_d  = '0;
          end else begin
            time_d = time_q - 8'd1;
          end
        end
      end

      OVER: begin
        rl_d = rl_seen;
        rr_d = rr_seen;
        if (rl_seen && rr_seen) begin
          state_d = COUNTDOWN;
          rl_d    = 1'b0;
          rr_d    = 1'b0;
          over_d  = WIN_NONE;
          count_d = COUNT_LOAD;
          time_d  = '0;
          grst_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Restart the second counter whenever the phase is about to change
  assign clr = (state_d != state_q);

  // Register stage: every output is driven straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      over_q  <= WIN_NONE;
      grst_q  <= 1'b0;
      count_q <= '0;
      time_q  <= '0;
      tom_q   <= '0;
      jer_q   <= '0;
      rl_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      over_q  <= over_d;
      grst_q  <= grst_d;
      count_q <= count_d;
      time_q  <= time_d;
      tom_q   <= tom_d;
      jer_q   <= jer_d;
      rl_q    <= rl_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.over        = over_q;
  assign bus.game_rst    = grst_q;
  assign bus.count       = count_q;
  assign bus.time_left   = time_q;
  assign bus.score_tom   = tom_q;
  assign bus.score_jerry = jer_q;

endmodule
